// File: rtl/qpsk_carrier_nco.sv
// QPSK I/Q carrier NCO: phase accumulator, quarter-wave sine ROM, one-deep symbol buffer.
// Define QPSK_COS_OUT_EN to build the cosine output; otherwise cos_out is tied to 0.
module qpsk_carrier_nco #(
  parameter int PHASE_W    = 16,
  parameter int LUT_ADDR_W = 5,
  parameter int DATA_W     = 11,
  parameter int AMP        = 1000
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     en,
  input  logic [PHASE_W-1:0]       freq_word,
  input  logic [1:0]               sym_in,
  input  logic                     sym_valid,
  output logic                     sym_ready,
  output logic signed [DATA_W-1:0] sin_out,
  output logic signed [DATA_W-1:0] cos_out,
  output logic                     out_valid,
  output logic                     underrun
);

  localparam int N     = 2 ** LUT_ADDR_W;
  localparam int MAG_W = DATA_W - 1;
  localparam int TOP_W = LUT_ADDR_W + 2;

  function automatic logic [MAG_W-1:0] table_entry(input int k);
    real angle;
    angle = 3.14159265358979323846 * real'(k) / (2.0 * real'(N));
    return MAG_W'($rtoi(real'(AMP) * $sin(angle) + 0.5));
  endfunction

  logic [MAG_W-1:0] sine_rom [0:N];

  generate
    for (genvar gi = 0; gi <= N; gi++) begin : g_rom
      assign sine_rom[gi] = table_entry(gi);
    end
  endgenerate

  logic [PHASE_W-1:0] acc_reg;
  logic [PHASE_W:0]   acc_sum;
  logic               wrap;
  logic               boundary;
  logic [1:0]         active_sym_reg;
  logic [1:0]         hold_reg;
  logic               hold_full_reg;
  logic [TOP_W-1:0]   phase_next;
  logic [TOP_W-1:0]   phase_reg;
  logic               p1_valid_reg;

  assign acc_sum  = {1'b0, acc_reg} + {1'b0, freq_word};
  assign wrap     = acc_sum[PHASE_W];
  assign boundary = en & wrap;
  assign sym_ready = ~hold_full_reg;

  // The symbol/45deg offset has no bits below the table index, so only the
  // quadrant+index slice of the phase sum is needed; truncated bits never carry.
  assign phase_next = acc_reg[PHASE_W-1 -: TOP_W]
                    + {active_sym_reg, 1'b1, {(TOP_W-3){1'b0}}};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc_reg        <= '0;
      active_sym_reg <= 2'd0;
      hold_reg       <= 2'd0;
      hold_full_reg  <= 1'b0;
      underrun       <= 1'b0;
      phase_reg      <= '0;
      p1_valid_reg   <= 1'b0;
      out_valid      <= 1'b0;
    end else begin
      underrun     <= boundary & ~hold_full_reg;
      p1_valid_reg <= en;
      out_valid    <= p1_valid_reg;
      if (en) begin
        acc_reg   <= acc_sum[PHASE_W-1:0];
        phase_reg <= phase_next;
      end
      // A held symbol is only consumed at a wrap; while full, sym_valid is ignored.
      if (boundary && hold_full_reg) begin
        active_sym_reg <= hold_reg;
        hold_full_reg  <= 1'b0;
      end else if (sym_valid && !hold_full_reg) begin
        hold_reg      <= sym_in;
        hold_full_reg <= 1'b1;
      end
    end
  end

  logic [1:0]              quad;
  logic [LUT_ADDR_W-1:0]   k_idx;
  logic [LUT_ADDR_W:0]     k_fwd;
  logic [LUT_ADDR_W:0]     k_mirror;
  logic [LUT_ADDR_W:0]     sin_idx;
  logic [MAG_W-1:0]        sin_mag;
  logic signed [DATA_W-1:0] sin_pos;
  logic signed [DATA_W-1:0] sin_next;

  assign quad     = phase_reg[TOP_W-1 -: 2];
  assign k_idx    = phase_reg[LUT_ADDR_W-1:0];
  assign k_fwd    = {1'b0, k_idx};
  assign k_mirror = (LUT_ADDR_W+1)'(N) - k_fwd;
  assign sin_idx  = quad[0] ? k_mirror : k_fwd;
  assign sin_mag  = sine_rom[sin_idx];
  assign sin_pos  = $signed({1'b0, sin_mag});
  assign sin_next = quad[1] ? -sin_pos : sin_pos;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sin_out <= '0;
    end else if (p1_valid_reg) begin
      sin_out <= sin_next;
    end
  end

`ifdef QPSK_COS_OUT_EN
  logic [1:0]               cos_quad;
  logic [LUT_ADDR_W:0]      cos_idx;
  logic [MAG_W-1:0]         cos_mag;
  logic signed [DATA_W-1:0] cos_pos;
  logic signed [DATA_W-1:0] cos_next;

  assign cos_quad = quad + 2'd1;
  assign cos_idx  = cos_quad[0] ? k_mirror : k_fwd;
  assign cos_mag  = sine_rom[cos_idx];
  assign cos_pos  = $signed({1'b0, cos_mag});
  assign cos_next = cos_quad[1] ? -cos_pos : cos_pos;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      cos_out <= '0;
    end else if (p1_valid_reg) begin
      cos_out <= cos_next;
    end
  end
`else
  assign cos_out = '0;
`endif

endmodule
